// File: rtl/ofdm_cp_strip_pkg.sv
// Shared types and constants for the OFDM cyclic-prefix stripper.
package ofdm_cp_strip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    PASS,
    PAD,
    DRAIN
  } state_e;

  localparam int REG_FFT_LEN  = 0;
  localparam int REG_CP_LEN   = 1;
  localparam int REG_NUM_SYMS = 2;

  localparam int FFT_LEN_RST  = 64;
  localparam int CP_LEN_RST   = 16;
  localparam int NUM_SYMS_RST = 0;
  localparam int MIN_FFT_LEN  = 8;

endpackage

// File: rtl/ofdm_cp_strip_setting_reg.sv
// Single settings-bus register; survives soft clear, only aresetn restores it.
module setting_reg #(
  parameter int              MY_ADDR   = 0,
  parameter int              AWIDTH    = 8,
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_stb,
  input  logic [AWIDTH-1:0] set_addr,
  input  logic [WIDTH-1:0]  set_data,
  output logic [WIDTH-1:0]  out_o
);

  logic [WIDTH-1:0] val_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      val_q <= RESET_VAL;
    else if (set_stb && (set_addr == AWIDTH'(MY_ADDR)))
      val_q <= set_data;
  end

  assign out_o = val_q;

endmodule

// File: rtl/ofdm_cp_strip.sv
// Drops each OFDM symbol's cyclic prefix and zero-pads truncated frames to a whole symbol.
// Define OFDM_CP_STRIP_STATS_EN to add frame/padded counters on rb_data.
module ofdm_cp_strip
  import ofdm_cp_strip_pkg::*;
#(
  parameter int BASE         = 0,
  parameter int WIDTH        = 32,
  parameter int MAX_LEN_LOG2 = 10
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             eob
`ifdef OFDM_CP_STRIP_STATS_EN
  ,
  output logic [63:0]      rb_data
`endif
);

  localparam int LW = MAX_LEN_LOG2;

  logic [LW-1:0] fft_reg, cp_reg;
  logic [15:0]   nsym_reg;
  logic          unused_set;
  assign unused_set = ^set_data[31:16];

  setting_reg #(.MY_ADDR(BASE + REG_FFT_LEN), .WIDTH(LW), .RESET_VAL(LW'(FFT_LEN_RST))) u_fft (
    .clk(clk), .rst_n(aresetn), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data[LW-1:0]), .out_o(fft_reg));
  setting_reg #(.MY_ADDR(BASE + REG_CP_LEN), .WIDTH(LW), .RESET_VAL(LW'(CP_LEN_RST))) u_cp (
    .clk(clk), .rst_n(aresetn), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data[LW-1:0]), .out_o(cp_reg));
  setting_reg #(.MY_ADDR(BASE + REG_NUM_SYMS), .WIDTH(16), .RESET_VAL(16'(NUM_SYMS_RST))) u_nsym (
    .clk(clk), .rst_n(aresetn), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data[15:0]), .out_o(nsym_reg));

  state_e        state_q, state_d;
  logic [LW-1:0] fft_q, fft_d, cp_q, cp_d;
  logic [15:0]   nsym_q, nsym_d;
  logic [LW-1:0] cp_cnt_q, cp_cnt_d, samp_cnt_q, samp_cnt_d;
  logic [15:0]   sym_cnt_q, sym_cnt_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic          olast_q, olast_d, oeob_q, oeob_d, ovld_q, ovld_d;
  logic          run, slot, in_rdy, load, sym_end, sym_done;

  assign run      = aresetn & ~clear;
  assign slot     = ~ovld_q | o_tready;
  assign sym_end  = (samp_cnt_q == fft_q - LW'(1));
  assign sym_done = (nsym_q != 16'd0) && (sym_cnt_q + 16'd1 == nsym_q);

  always_comb begin
    state_d    = state_q;
    fft_d      = fft_q;
    cp_d       = cp_q;
    nsym_d     = nsym_q;
    cp_cnt_d   = cp_cnt_q;
    samp_cnt_d = samp_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    odata_d    = odata_q;
    olast_d    = olast_q;
    oeob_d     = oeob_q;
    in_rdy     = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      IDLE: if (i_tvalid) begin
        fft_d      = (fft_reg < LW'(MIN_FFT_LEN)) ? LW'(MIN_FFT_LEN) : fft_reg;
        cp_d       = cp_reg;
        nsym_d     = nsym_reg;
        cp_cnt_d   = '0;
        samp_cnt_d = '0;
        sym_cnt_d  = '0;
        state_d    = (cp_reg != '0) ? SKIP : PASS;
      end
      SKIP: begin
        in_rdy = 1'b1;
        if (i_tvalid) begin
          if (i_tlast) begin
            cp_cnt_d = '0;
            state_d  = IDLE;
          end else if (cp_cnt_q == cp_q - LW'(1)) begin
            cp_cnt_d = '0;
            state_d  = PASS;
          end else begin
            cp_cnt_d = cp_cnt_q + LW'(1);
          end
        end
      end
      PASS: begin
        in_rdy = slot;
        if (i_tvalid && slot) begin
          load    = 1'b1;
          odata_d = i_tdata;
          olast_d = sym_end;
          oeob_d  = 1'b0;
          if (sym_end) begin
            samp_cnt_d = '0;
            sym_cnt_d  = sym_cnt_q + 16'd1;
            oeob_d     = sym_done | i_tlast;
            if (sym_done)     state_d = i_tlast ? IDLE : DRAIN;
            else if (i_tlast) state_d = IDLE;
            else              state_d = (cp_q != '0) ? SKIP : PASS;
          end else begin
            samp_cnt_d = samp_cnt_q + LW'(1);
            if (i_tlast) state_d = PAD;
          end
        end
      end
      PAD: if (slot) begin
        // Input is held off; the zero that completes the symbol also closes the frame.
        load       = 1'b1;
        odata_d    = '0;
        olast_d    = sym_end;
        oeob_d     = sym_end;
        samp_cnt_d = sym_end ? '0 : samp_cnt_q + LW'(1);
        if (sym_end) state_d = IDLE;
      end
      DRAIN: begin
        in_rdy = 1'b1;
        if (i_tvalid && i_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ovld_d = load | (ovld_q & ~o_tready);
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      state_q    <= IDLE;
      fft_q      <= '0;
      cp_q       <= '0;
      nsym_q     <= '0;
      cp_cnt_q   <= '0;
      samp_cnt_q <= '0;
      sym_cnt_q  <= '0;
      odata_q    <= '0;
      olast_q    <= 1'b0;
      oeob_q     <= 1'b0;
      ovld_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fft_q      <= fft_d;
      cp_q       <= cp_d;
      nsym_q     <= nsym_d;
      cp_cnt_q   <= cp_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      odata_q    <= odata_d;
      olast_q    <= olast_d;
      oeob_q     <= oeob_d;
      ovld_q     <= ovld_d;
    end
  end

  assign i_tready = in_rdy & run;
  assign o_tdata  = odata_q;
  assign o_tlast  = olast_q;
  assign o_tvalid = ovld_q;
  assign eob      = oeob_q;

`ifdef OFDM_CP_STRIP_STATS_EN
  logic [31:0] frames_q, padded_q;

  always_ff @(posedge clk) begin
    if (!run) begin
      frames_q <= '0;
      padded_q <= '0;
    end else if (load && oeob_d) begin
      if (frames_q != '1) frames_q <= frames_q + 32'd1;
      if (state_q == PAD && padded_q != '1) padded_q <= padded_q + 32'd1;
    end
  end

  assign rb_data = {padded_q, frames_q};
`endif

endmodule

// File: tb/tb_ofdm_cp_strip.sv
// Scoreboard bench for ofdm_cp_strip: symbol-level reference model, decoupled monitor.
module tb_ofdm_cp_strip;

  logic        clk = 1'b0, aresetn = 1'b0, clear = 1'b0, set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0, i_tvalid = 1'b0, i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast, o_tvalid, eob;
  logic        o_tready = 1'b1;
`ifdef OFDM_CP_STRIP_STATS_EN
  logic [63:0] rb_data;
`endif

  always #5 clk = ~clk;

  ofdm_cp_strip dut (
    .clk(clk), .aresetn(aresetn), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .eob(eob)
`ifdef OFDM_CP_STRIP_STATS_EN
    , .rb_data(rb_data)
`endif
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        e;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] fr[$];
  int          checks = 0, failures = 0;
  int          cfg_fft = 64, cfg_cp = 16, cfg_nsym = 0;
  bit          mon_en = 1'b0, rnd_ready = 1'b0;
  bit          hold_v = 1'b0;
  beat_t       held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per accepted output beat, and checks stalled beats hold.
  always @(negedge clk) begin
    if (!mon_en) hold_v <= 1'b0;
    else begin
      if (hold_v && o_tvalid) check("stall_hold", {o_tdata, o_tlast, eob}, held);
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none at %0t", {o_tdata, o_tlast, eob}, $time);
        end else begin
          check("beat", {o_tdata, o_tlast, eob}, exp_q.pop_front());
        end
      end
      hold_v <= o_tvalid && !o_tready;
      held   <= {o_tdata, o_tlast, eob};
    end
  end

  always @(posedge clk) begin
    #1 o_tready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
  end

  task automatic wr(input int a, input int v);
    set_stb  = 1'b1;
    set_addr = 8'(a);
    set_data = 32'(v);
    @(posedge clk); #1;
    set_stb  = 1'b0;
    case (a)
      0: cfg_fft  = v & 'h3ff;
      1: cfg_cp   = v & 'h3ff;
      2: cfg_nsym = v & 'hffff;
      default: ;
    endcase
  endtask

  task automatic make_frame(input int n, input bit rnd);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(rnd ? $urandom : 32'(i));
  endtask

  // Reference: walk the frame symbol by symbol (CP, then FFT body) using the current config.
  task automatic model_frame();
    int fft, n, pos, sym, avail;
    bit fin;
    beat_t b;
    fft = (cfg_fft < 8) ? 8 : cfg_fft;
    n = fr.size();
    pos = 0;
    sym = 0;
    forever begin
      if (n <= pos + cfg_cp) return;
      pos += cfg_cp;
      avail = n - pos;
      if (avail < fft) begin
        for (int k = 0; k < fft; k++) begin
          b.d = (k < avail) ? fr[pos+k] : 32'd0;
          b.l = (k == fft - 1);
          b.e = (k == fft - 1);
          exp_q.push_back(b);
        end
        return;
      end
      fin = (pos + fft == n) || (cfg_nsym != 0 && sym + 1 == cfg_nsym);
      for (int k = 0; k < fft; k++) begin
        b.d = fr[pos+k];
        b.l = (k == fft - 1);
        b.e = fin && (k == fft - 1);
        exp_q.push_back(b);
      end
      pos += fft;
      sym++;
      if (fin) return;
    end
  endtask

  task automatic send(input int n_send, input bit gaps);
    int t;
    for (int i = 0; i < n_send; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        i_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      i_tvalid = 1'b1;
      i_tdata  = fr[i];
      i_tlast  = (i == fr.size() - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (i_tready) break;
        if (++t > 2000) begin
          checks++;
          failures++;
          $display("FAIL input_timeout actual=i_tready_low required=accept sample=%0d", i);
          break;
        end
      end
      @(posedge clk); #1;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit rnd, input bit gaps);
    make_frame(n, rnd);
    model_frame();
    send(n, gaps);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0 beats pending", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", o_tvalid, 0);
    check("rst_tlast",  o_tlast, 0);
    check("rst_eob",    eob, 0);
    check("rst_tdata",  o_tdata, 0);
    check("rst_tready", i_tready, 0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    mon_en  = 1'b1;

    // two symbols, full throughput
    wr(2, 2);
    run_frame(160, 0, 0);
    wait_idle();

    // same with random backpressure and input gaps
    rnd_ready = 1'b1;
    run_frame(160, 0, 1);
    wait_idle();
    rnd_ready = 1'b0;

    // truncated frame -> padded
    wr(2, 0);
    run_frame(51, 0, 0);
    wait_idle();

    // tlast inside CP, then a clean frame
    run_frame(11, 0, 0);
    run_frame(160, 1, 0);
    wait_idle();

    // num_syms 1 with drain, and a mid-frame cp_len write that only hits the next frame
    wr(2, 1);
    make_frame(300, 0);
    model_frame();
    fork
      send(300, 0);
      begin
        repeat (60) @(posedge clk);
        #1 wr(1, 0);
      end
    join
    wait_idle();
    run_frame(100, 1, 0);
    wait_idle();

    // synchronous reset mid-PASS
    wr(0, 32);
    wr(1, 4);
    wr(2, 1);
    mon_en = 1'b0;
    make_frame(200, 1);
    send(40, 0);
    aresetn = 1'b0;
    @(negedge clk);
    check("rst_mid_tready", i_tready, 0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    check("rst_mid_tvalid", o_tvalid, 0);
    check("rst_mid_tdata",  o_tdata, 0);
    check("rst_mid_tlast",  o_tlast, 0);
    check("rst_mid_eob",    eob, 0);
    exp_q.delete();
    cfg_fft  = 64;
    cfg_cp   = 16;
    cfg_nsym = 0;
    mon_en   = 1'b1;
    run_frame(180, 1, 0);
    wait_idle();

    // randomized configs and frame lengths
    rnd_ready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      case ($urandom_range(3))
        0: wr(0, 4);
        1: wr(0, 8);
        2: wr(0, 16);
        default: wr(0, 32);
      endcase
      wr(1, int'($urandom_range(8)));
      wr(2, int'($urandom_range(3)));
      run_frame(int'($urandom_range(1, 150)), 1, 1);
      wait_idle();
    end
    rnd_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ofdm_cp_strip.md
# ofdm_cp_strip

Cyclic-prefix remover that sits directly downstream of the Schmidl & Cox synchronizer. It consumes the CFO-corrected, frame-aligned sample stream and drops each symbol's CP. It forwards exactly FFT-length symbols, each closed by `o_tlast`, to the FFT. Truncated frames are zero-padded to a whole symbol, so the FFT never sees a short packet.

## Interface
Parameters:
- `BASE`, 0: settings-bus base address.
- `WIDTH`, 32: sample width (sc16, I in [31:16], Q in [15:0]).
- `MAX_LEN_LOG2`, 10: width of the length counters.

Ports:
- `clk`  in  1: clock.
- `aresetn`  in  1: synchronous, active-low reset.
- `clear`  in  1: synchronous soft clear. Same effect as reset, except settings registers are kept.
- `set_stb`, `set_addr`, `set_data`  in  1/8/32: settings bus.
- `i_tdata`  in  WIDTH: input sample.
- `i_tlast`  in  1: last sample of the input frame.
- `i_tvalid`  in  1: input valid.
- `i_tready`  out  1: input ready.
- `o_tdata`  out  WIDTH: output sample.
- `o_tlast`  out  1: last sample of each FFT symbol.
- `o_tvalid`  out  1: output valid.
- `o_tready`  in  1: output ready.
- `eob`  out  1: qualified by `o_tvalid`. High together with `o_tlast` on the final symbol of a frame.

## Operation
Settings registers:
- BASE+0 `fft_len[9:0]`: reset value 64. Values below 8 are clamped to 8.
- BASE+1 `cp_len[9:0]`: reset value 16.
- BASE+2 `num_syms[15:0]`: reset value 0. Zero means unlimited; the frame runs until input tlast.
- Registers update immediately. Their shadow copies are latched only on the IDLE→frame transition, so a write mid-frame takes effect on the next frame.

State machine:
- **IDLE**
  - On the first `i_tvalid`, latch the shadows and clear the counters.
  - Go to SKIP if `cp_len`≠0, else PASS. The triggering sample is not consumed in IDLE.
- **SKIP**
  - `i_tready`=1. Samples are discarded and `cp_cnt` increments.
  - At `cp_len` samples → PASS.
  - `i_tlast` in SKIP → IDLE, with no output.
- **PASS**
  - Forward samples and increment `samp_cnt`.
  - At `samp_cnt`=`fft_len`-1: `o_tlast`=1 and `sym_cnt` increments.
  - If `sym_cnt` reaches `num_syms`: `eob`=1, then go to DRAIN (or IDLE if `i_tlast`).
  - Otherwise go to SKIP/PASS for the next symbol (or IDLE if `i_tlast`, with `eob`=1).
  - `i_tlast` before the symbol is full: that sample is forwarded, then go to PAD.
- **PAD**
  - `i_tready`=0. Output zeros until `samp_cnt` reaches `fft_len`-1.
  - The last zero carries `o_tlast`=1 and `eob`=1, then → IDLE.
- **DRAIN**
  - `i_tready`=1. Input is discarded until `i_tlast`, then → IDLE.

Frame-level rules:
- Input tlast coinciding with a symbol end is a normal end of frame: `eob`=1 and no padding.
- Output sample count per frame is always a multiple of `fft_len`.

## Timing
- Reset/clear values:
  - `o_tvalid`=0, `o_tlast`=0, `eob`=0, `o_tdata`=0.
  - State is IDLE and all counters are 0.
  - `i_tready`=0 during reset.
- Output is a single registered stage. Latency from input handshake to `o_tvalid` is 1 cycle.
- In PASS, `i_tready` = `~o_tvalid | o_tready`. Full throughput is one sample per cycle, with no bubbles across symbol or CP boundaries.
- SKIP and DRAIN accept one sample per cycle regardless of `o_tready`.
- `o_tdata`, `o_tlast` and `eob` hold stable while `o_tvalid` is high and `o_tready` is low.
- Reset or clear mid-frame:
  - Any pending output beat is dropped.
  - The next accepted input is treated as a frame start.
  - Downstream sees no partial symbol completion.

## Configuration
- `OFDM_CP_STRIP_STATS_EN` defined:
  - Adds two 32-bit saturating counters: frames completed, and frames padded (truncated).
  - Readable on `rb_data[63:0]` (extra output port), with `{padded, frames}`.
  - Both counters are cleared by reset/clear.
- Macro undefined: no counters and no `rb_data` port.

## Structure
- Package `ofdm_cp_strip_pkg`:
  - State enum (IDLE, SKIP, PASS, PAD, DRAIN).
  - Register offsets `REG_FFT_LEN`=0, `REG_CP_LEN`=1, `REG_NUM_SYMS`=2.
  - Reset defaults and `MIN_FFT_LEN`=8.
- Sub-module: each register is a `setting_reg` instance.
- FSM, counters and output register stay in the top module.

## Test plan
- fft 64, cp 16, num_syms 2; 160 input samples with tlast on the last → 128 outputs equal to inputs 16–79 and 96–159; `o_tlast` at outputs 63 and 127; `eob` only at 127.
- Same config, with `o_tready` toggling at 50% random → identical data/tlast sequence, no drops or duplicates, data stable while stalled.
- fft 64, cp 16, num_syms 0; tlast at input 50 → 35 data outputs (inputs 16–50), then 29 zeros; `o_tlast`+`eob` on the 64th output.
- tlast at input 10 (inside CP) → no output; the next frame starts cleanly.
- num_syms 1, 300-sample frame → 64 outputs, rest drained with `i_tready`=1. A `cp_len`=0 write mid-frame applies only to the next frame.
- `aresetn` low for 1 cycle mid-PASS → outputs zero on the next cycle, FSM IDLE; settings return to 64/16/0.
